pattern_checker: RTL

Receive-side BERT checker that consumes the word stream produced by `pattern_generator` after the link under test and compares it against a locally regenerated reference. It supports PRBS and fixed-pattern modes, self-synchronises by seeding from received data, and detects and recovers from loss of lock. It accumulates saturating error and word counters for readout by the BERT control logic.

---
 rtl/pattern_checker_pkg.sv | 27 ++
 rtl/popcount.sv | 17 +
 rtl/prbs.sv | 61 ++++++
 rtl/pattern_checker.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pattern_checker_pkg.sv
// Shared BERT definitions: checker state encoding and small elaboration helpers.
package pattern_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEED  = 2'd1,
    ST_CHECK = 2'd2
  } bert_state_e;

  function automatic int bert_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Second feedback tap of the standard maximal-length PRBS polynomials.
  function automatic int prbs_tap(input int len);
    case (len)
      7:       return 6;
      9:       return 5;
      11:      return 9;
      15:      return 14;
      23:      return 18;
      31:      return 28;
      default: return len - 1;
    endcase
  endfunction

endpackage

// File: rtl/popcount.sv
// Combinational population count of a word.
module popcount #(
  parameter  int Width = 16,
  localparam int CntW  = $clog2(Width + 1)
) (
  input  logic [Width-1:0] in_bits,
  output logic [CntW-1:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < Width; i++) begin
      count = count + CntW'(in_bits[i]);
    end
  end

endmodule

// File: rtl/prbs.sv
// Word-parallel Fibonacci PRBS: bit 0 of each word is the oldest bit in time.
module prbs
  import pattern_checker_pkg::*;
#(
  parameter int OutBits    = 16,
  parameter int PRBSLength = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [PRBSLength-1:0] load_in,
  input  logic                  seed_en,
  input  logic [OutBits-1:0]    seed_in,
  input  logic                  run,
  input  logic                  out_inv,
  output logic [OutBits-1:0]    out,
  output logic                  seed_good
);

  localparam int Tap = prbs_tap(PRBSLength);

  logic [PRBSLength-1:0] state_q, state_d;
  logic [PRBSLength-1:0] gen_s, seed_s;
  logic [OutBits-1:0]    gen_w;
  logic                  fb;

  always_comb begin
    gen_s  = state_q;
    seed_s = state_q;
    gen_w  = '0;
    fb     = 1'b0;
    for (int i = 0; i < OutBits; i++) begin
      fb       = gen_s[PRBSLength-1] ^ gen_s[Tap-1];
      gen_w[i] = fb;
      gen_s    = {gen_s[PRBSLength-2:0], fb};
      // received bits are shifted in exactly as the generator would have produced them
      seed_s   = {seed_s[PRBSLength-2:0], seed_in[i]};
    end
    state_d = state_q;
    if (load) begin
      state_d = load_in;
    end else if (seed_en) begin
      state_d = seed_s;
    end else if (run) begin
      state_d = gen_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign out       = gen_w ^ {OutBits{out_inv}};
  // judged on the state the seed word would leave behind, so lock is not delayed a word
  assign seed_good = |seed_s;

endmodule

// File: rtl/pattern_checker.sv
// Receive-side BERT checker: self-seeds from received words, compares, tracks lock.
//   state    | meaning
//   ST_IDLE  | disabled; counters hold
//   ST_SEED  | shifting received words into the local reference
//   ST_CHECK | comparing received words against the reference (locked)
module pattern_checker
  import pattern_checker_pkg::*;
#(
  parameter int OutBits     = 16,
  parameter int PattLength  = 32,
  parameter int PRBSLength  = 31,
  parameter int ErrCntBits  = 32,
  parameter int WordCntBits = 48,
  parameter int LossThresh  = 4,
  parameter int LossWords   = 8
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        enable,
  input  logic                                        pattern,
  input  logic                                        load,
  input  logic [bert_max(PattLength, PRBSLength)-1:0] load_in,
  input  logic                                        clear,
  input  logic [OutBits-1:0]                          rx_data,
  input  logic                                        rx_valid,
  input  logic                                        rx_inv,
  output logic                                        locked,
  output logic                                        err_flag,
  output logic [ErrCntBits-1:0]                       err_count,
  output logic [WordCntBits-1:0]                      word_count,
  output logic                                        err_sat
);

  localparam int CntW     = $clog2(OutBits + 1);
  localparam int SeedPatt = (PattLength + OutBits - 1) / OutBits;
  localparam int SeedPrbs = (PRBSLength + OutBits - 1) / OutBits;
  localparam int SeedW    = $clog2(bert_max(SeedPatt, SeedPrbs) + 1);
  localparam int RunW     = $clog2(LossWords + 1);

  localparam logic [CntW-1:0] LossThr = CntW'(LossThresh);
  localparam logic [RunW:0]   RunFull = (RunW + 1)'(LossWords);

  bert_state_e            state_q, state_d;
  logic [PattLength-1:0]  patt_q, patt_d;
  logic [SeedW-1:0]       seed_cnt_q, seed_cnt_d;
  logic [RunW-1:0]        run_q, run_d;
  logic                   cmp_q, cmp_d;
  logic [CntW-1:0]        e_q, e_d;
  logic                   err_flag_q, err_flag_d;
  logic [ErrCntBits-1:0]  err_count_q, err_count_d;
  logic [WordCntBits-1:0] word_count_q, word_count_d;
  logic                   err_sat_q, err_sat_d;

  logic [OutBits-1:0]    d, exp_word, prbs_out;
  logic [CntW-1:0]       e_now;
  logic                  prbs_seed_good, seed_word, cmp_word;
  logic [SeedW-1:0]      seed_need;
  logic [SeedW:0]        seed_inc;
  logic [RunW:0]         run_inc;
  logic [PattLength-1:0] patt_ld;
  logic [ErrCntBits:0]   err_sum;

  assign d         = rx_data ^ {OutBits{rx_inv}};
  assign exp_word  = pattern ? patt_q[OutBits-1:0] : prbs_out;
  assign seed_need = pattern ? SeedW'(SeedPatt) : SeedW'(SeedPrbs);
  assign seed_inc  = {1'b0, seed_cnt_q} + (SeedW + 1)'(1);
  assign run_inc   = {1'b0, run_q} + (RunW + 1)'(1);
  assign patt_ld   = load_in[PattLength-1:0];

  prbs #(
    .OutBits   (OutBits),
    .PRBSLength(PRBSLength)
  ) u_prbs (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_in  (load_in[PRBSLength-1:0]),
    .seed_en  (seed_word & ~pattern),
    .seed_in  (d),
    .run      (cmp_word & ~pattern),
    .out_inv  (1'b0),
    .out      (prbs_out),
    .seed_good(prbs_seed_good)
  );

  popcount #(
    .Width(OutBits)
  ) u_popcount (
    .in_bits(d ^ exp_word),
    .count  (e_now)
  );

  always_comb begin
    state_d    = state_q;
    patt_d     = patt_q;
    seed_cnt_d = seed_cnt_q;
    run_d      = run_q;
    seed_word  = 1'b0;
    cmp_word   = 1'b0;
    if (load) begin
      // first compared word must be the top word of load_in
      patt_d     = (patt_ld << OutBits) | (patt_ld >> (PattLength - OutBits));
      seed_cnt_d = '0;
      run_d      = '0;
      state_d    = enable ? ST_CHECK : ST_IDLE;
    end else if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d    = ST_SEED;
          seed_cnt_d = '0;
          run_d      = '0;
        end
        ST_SEED: begin
          if (rx_valid) begin
            seed_word = 1'b1;
            if (pattern) begin
              patt_d = (patt_q >> OutBits) | (PattLength'(d) << (PattLength - OutBits));
            end
            if (seed_inc >= (SeedW + 1)'(seed_need) && (pattern || prbs_seed_good)) begin
              state_d    = ST_CHECK;
              seed_cnt_d = '0;
              run_d      = '0;
            end else if (seed_inc >= (SeedW + 1)'(seed_need)) begin
              seed_cnt_d = seed_need;
            end else begin
              seed_cnt_d = seed_inc[SeedW-1:0];
            end
          end
        end
        ST_CHECK: begin
          if (rx_valid) begin
            cmp_word = 1'b1;
            if (pattern) begin
              patt_d = (patt_q >> OutBits) | (patt_q << (PattLength - OutBits));
            end
            if (e_now >= LossThr) begin
              if (run_inc >= RunFull) begin
                state_d    = ST_SEED;
                run_d      = '0;
                seed_cnt_d = '0;
              end else begin
                run_d = run_inc[RunW-1:0];
              end
            end else begin
              run_d = '0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cmp_d        = cmp_word;
    e_d          = cmp_word ? e_now : '0;
    err_flag_d   = cmp_word && (e_now != '0);
    err_count_d  = err_count_q;
    word_count_d = word_count_q;
    err_sat_d    = err_sat_q;
    err_sum      = {1'b0, err_count_q} + (ErrCntBits + 1)'(e_q);
    if (clear) begin
      err_count_d  = '0;
      word_count_d = '0;
      err_sat_d    = 1'b0;
    end else if (cmp_q) begin
      if (err_sum[ErrCntBits]) begin
        err_count_d = '1;
        err_sat_d   = 1'b1;
      end else begin
        err_count_d = err_sum[ErrCntBits-1:0];
      end
      if (word_count_q != '1) begin
        word_count_d = word_count_q + WordCntBits'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      patt_q       <= '0;
      seed_cnt_q   <= '0;
      run_q        <= '0;
      cmp_q        <= 1'b0;
      e_q          <= '0;
      err_flag_q   <= 1'b0;
      err_count_q  <= '0;
      word_count_q <= '0;
      err_sat_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      patt_q       <= patt_d;
      seed_cnt_q   <= seed_cnt_d;
      run_q        <= run_d;
      cmp_q        <= cmp_d;
      e_q          <= e_d;
      err_flag_q   <= err_flag_d;
      err_count_q  <= err_count_d;
      word_count_q <= word_count_d;
      err_sat_q    <= err_sat_d;
    end
  end

  assign locked     = (state_q == ST_CHECK);
  assign err_flag   = err_flag_q;
  assign err_count  = err_count_q;
  assign word_count = word_count_q;
  assign err_sat    = err_sat_q;

endmodule
